// File: rtl/regfile_arb_pkg.sv
// Shared constants, types and helpers for the register-file read arbiter.
// Used by regfile_read_arbiter and rr_priority_picker.
package regfile_arb_pkg;

    localparam int NUM_REGS       = 16;
    localparam int REG_SEL_BITS   = $clog2(NUM_REGS);
    localparam int MAX_REQUESTERS = 8;

    typedef logic [REG_SEL_BITS-1:0] reg_sel_t;

    function automatic logic [2:0] onehot_to_index(input logic [MAX_REQUESTERS-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQUESTERS; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible bit at or after i_ptr, wrapping
// modulo REQUESTERS. Returns the winner as one-hot and as an index.
module rr_priority_picker
    import regfile_arb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] i_eligible,
    input  logic [IDX_W-1:0]      i_ptr,
    output logic [REQUESTERS-1:0] o_winner_oh,
    output logic [IDX_W-1:0]      o_winner_idx,
    output logic                  o_any
);

    logic [IDX_W:0]            w_pos;
    logic                      w_found;
    logic [MAX_REQUESTERS-1:0] w_oh_wide;

    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        o_winner_oh = '0;
        w_found     = 1'b0;
        w_pos       = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(REQUESTERS)) w_pos = w_pos - (IDX_W+1)'(REQUESTERS);
            if (!w_found && i_eligible[w_pos[IDX_W-1:0]]) begin
                o_winner_oh[w_pos[IDX_W-1:0]] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_oh_wide                   = '0;
        w_oh_wide[REQUESTERS-1:0]   = o_winner_oh;
        o_winner_idx                = IDX_W'(onehot_to_index(w_oh_wide));
    end

    assign o_any = |i_eligible;

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the 16:1 register-file read mux among REQUESTERS clients: arbitrate, then
// capture. Build option REGFILE_ARB_FIXED_PRIO0_EN gives client 0 absolute priority.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int REQUESTERS = 4
) (
    input  logic                                     CLK,
    input  logic                                     RESET,
    input  logic [REQUESTERS-1:0]                    REQ,
    input  logic [REQUESTERS-1:0][REG_SEL_BITS-1:0]  ADDR,
    input  logic [BITS-1:0]                          MUX_DATA,
    output logic [REG_SEL_BITS-1:0]                  MUX_SELECT,
    output logic [REQUESTERS-1:0]                    GNT,
    output logic [BITS-1:0]                          RDATA,
    output logic [REQUESTERS-1:0]                    RVALID,
    output logic                                     BUSY
);

    localparam int IDX_W = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0] r_gnt;
    reg_sel_t              r_sel;
    logic [IDX_W-1:0]      r_ptr;
    logic [BITS-1:0]       r_rdata;
    logic [REQUESTERS-1:0] r_rvalid;

    logic [REQUESTERS-1:0] w_eligible;
    logic [REQUESTERS-1:0] w_pick_elig;
    logic [REQUESTERS-1:0] w_pick_oh;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    logic [REQUESTERS-1:0] w_win_oh;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_any;
    logic                  w_ptr_upd;
    logic [IDX_W-1:0]      w_ptr_next;

    // The current grantee is masked so a held request cannot win two cycles in a row.
    assign w_eligible = REQ & ~r_gnt;
    assign w_any      = |w_eligible;

`ifdef REGFILE_ARB_FIXED_PRIO0_EN
    assign w_pick_elig = w_eligible & ~REQUESTERS'(1);
    assign w_win_oh    = w_eligible[0] ? REQUESTERS'(1) : w_pick_oh;
    assign w_win_idx   = w_eligible[0] ? '0 : w_pick_idx;
    assign w_ptr_upd   = !w_eligible[0] && w_pick_any;
`else
    assign w_pick_elig = w_eligible;
    assign w_win_oh    = w_pick_oh;
    assign w_win_idx   = w_pick_idx;
    assign w_ptr_upd   = w_pick_any;
`endif

    rr_priority_picker #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IDX_W)
    ) u_picker (
        .i_eligible   (w_pick_elig),
        .i_ptr        (r_ptr),
        .o_winner_oh  (w_pick_oh),
        .o_winner_idx (w_pick_idx),
        .o_any        (w_pick_any)
    );

    assign w_ptr_next = (w_win_idx == IDX_W'(REQUESTERS-1)) ? '0 : w_win_idx + IDX_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_gnt    <= '0;
            r_sel    <= '0;
            r_ptr    <= '0;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_gnt    <= w_win_oh;
            r_rvalid <= r_gnt;
            if (w_any) r_sel <= ADDR[w_win_idx];
            if (w_ptr_upd) r_ptr <= w_ptr_next;
            // RDATA only moves when a grant from the previous cycle is being captured.
            if (|r_gnt) r_rdata <= MUX_DATA;
        end
    end

    assign MUX_SELECT = r_sel;
    assign GNT        = r_gnt;
    assign RDATA      = r_rdata;
    assign RVALID     = r_rvalid;
    assign BUSY       = |r_gnt;

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(r_gnt));
    a_rvalid_lag: assert property (@(posedge CLK) disable iff (RESET) r_rvalid == $past(r_gnt));

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter; expected read returns go through a
// scoreboard queue. Honours REGFILE_ARB_FIXED_PRIO0_EN for the all-request rotation.
module tb_regfile_read_arbiter;

    localparam int BITS = 32;
    localparam int N    = 4;

    typedef struct {
        logic [N-1:0]    tag;
        logic [BITS-1:0] data;
    } exp_t;

    logic              CLK;
    logic              RESET;
    logic [N-1:0]      REQ;
    logic [N-1:0][3:0] ADDR;
    logic [BITS-1:0]   MUX_DATA;
    logic [3:0]        MUX_SELECT;
    logic [N-1:0]      GNT;
    logic [BITS-1:0]   RDATA;
    logic [N-1:0]      RVALID;
    logic              BUSY;

    logic [BITS-1:0] regs [16];
    exp_t            sb_q[$];
    int              total = 0;
    int              bad   = 0;

    regfile_read_arbiter #(.BITS(BITS), .REQUESTERS(N)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .ADDR       (ADDR),
        .MUX_DATA   (MUX_DATA),
        .MUX_SELECT (MUX_SELECT),
        .GNT        (GNT),
        .RDATA      (RDATA),
        .RVALID     (RVALID),
        .BUSY       (BUSY)
    );

    assign MUX_DATA = regs[MUX_SELECT];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [N-1:0] oh(input int c);
        logic [N-1:0] one;
        one = 1;
        return one << c;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int client, input int addr);
        exp_t e;
        e.tag  = oh(client);
        e.data = regs[addr];
        sb_q.push_back(e);
    endtask

    // Scoreboard: every RVALID must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RESET && RVALID != '0) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: rvalid=%b rdata=%h, no read outstanding", RVALID, RDATA);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (RVALID !== e.tag || RDATA !== e.data) begin
                    bad++;
                    $display("FAIL sb_return: got tag=%b data=%h expected tag=%b data=%h",
                             RVALID, RDATA, e.tag, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        RESET = 1'b1;
        REQ   = '0;
        ADDR  = '0;
        step();
        step();
        total++;
        if ({GNT, RVALID, RDATA, MUX_SELECT, BUSY} !== '0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b rvalid=%b rdata=%h sel=%0d busy=%b, all zero expected",
                     GNT, RVALID, RDATA, MUX_SELECT, BUSY);
        end
        RESET   = 1'b0;
        REQ     = 4'b0001;
        ADDR[0] = 4'd5;
        step();
        total++;
        if (GNT !== 4'b0001 || MUX_SELECT !== 4'd5 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_grant: gnt=%b sel=%0d busy=%b expected gnt=0001 sel=5 busy=1",
                     GNT, MUX_SELECT, BUSY);
        end
        REQ = '0;
        #2 RESET = 1'b1;
        #1;
        total++;
        if ({GNT, RVALID, MUX_SELECT, BUSY} !== '0) begin
            bad++;
            $display("FAIL reset_async: gnt=%b rvalid=%b sel=%0d busy=%b, all zero expected",
                     GNT, RVALID, MUX_SELECT, BUSY);
        end
        step();
        total++;
        if (RVALID !== '0 || RDATA !== '0) begin
            bad++;
            $display("FAIL reset_inflight: rvalid=%b rdata=%h expected rvalid=0 rdata=0", RVALID, RDATA);
        end
        RESET = 1'b0;
    endtask

    task automatic test_rotation();
        int exp_w [8];
        int addr  [4];
`ifdef REGFILE_ARB_FIXED_PRIO0_EN
        exp_w = '{0, 1, 0, 2, 0, 3, 0, 1};
`else
        exp_w = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        addr = '{3, 7, 11, 15};
        for (int c = 0; c < N; c++) ADDR[c] = 4'(addr[c]);
        for (int i = 0; i < 8; i++) push_exp(exp_w[i], addr[exp_w[i]]);
        REQ = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] exp_rv;
            step();
            exp_rv = (i == 0) ? '0 : oh(exp_w[i-1]);
            total++;
            if (GNT !== oh(exp_w[i]) || MUX_SELECT !== 4'(addr[exp_w[i]]) || RVALID !== exp_rv) begin
                bad++;
                $display("FAIL rotation[%0d]: gnt=%b sel=%0d rvalid=%b expected gnt=%b sel=%0d rvalid=%b",
                         i, GNT, MUX_SELECT, RVALID, oh(exp_w[i]), addr[exp_w[i]], exp_rv);
            end
        end
        REQ = '0;
        step();
        total++;
        if (GNT !== '0 || RVALID !== oh(exp_w[7])) begin
            bad++;
            $display("FAIL rotation_drain: gnt=%b rvalid=%b expected gnt=0000 rvalid=%b",
                     GNT, RVALID, oh(exp_w[7]));
        end
    endtask

    task automatic test_single_read();
        ADDR[2] = 4'd9;
        REQ     = 4'b0100;
        push_exp(2, 9);
        step();
        total++;
        if (GNT !== 4'b0100 || MUX_SELECT !== 4'd9) begin
            bad++;
            $display("FAIL single_grant: gnt=%b sel=%0d expected gnt=0100 sel=9", GNT, MUX_SELECT);
        end
        REQ = '0;
        step();
        total++;
        if (RDATA !== 32'hDEADBEEF || RVALID !== 4'b0100 || GNT !== '0) begin
            bad++;
            $display("FAIL single_capture: rdata=%h rvalid=%b gnt=%b expected deadbeef 0100 0000",
                     RDATA, RVALID, GNT);
        end
        step();
        total++;
        if (RVALID !== '0) begin
            bad++;
            $display("FAIL single_rvalid_drop: rvalid=%b expected 0000", RVALID);
        end
    endtask

    task automatic test_held_req();
        logic [N-1:0] exp_g [4];
        logic [N-1:0] exp_v [4];
        exp_g = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
        exp_v = '{4'b0000, 4'b0010, 4'b0000, 4'b0010};
        ADDR[1] = 4'd7;
        push_exp(1, 7);
        push_exp(1, 7);
        REQ = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (GNT !== exp_g[i] || RVALID !== exp_v[i]) begin
                bad++;
                $display("FAIL held_req[%0d]: gnt=%b rvalid=%b expected gnt=%b rvalid=%b",
                         i, GNT, RVALID, exp_g[i], exp_v[i]);
            end
        end
        REQ = '0;
        step();
        total++;
        if (GNT !== '0 || RVALID !== '0) begin
            bad++;
            $display("FAIL held_release: gnt=%b rvalid=%b expected 0000 0000", GNT, RVALID);
        end
    endtask

    task automatic test_idle();
        logic [BITS-1:0] old;
        ADDR[3] = 4'd15;
        REQ     = 4'b1000;
        push_exp(3, 15);
        step();
        total++;
        if (GNT !== 4'b1000 || MUX_SELECT !== 4'd15) begin
            bad++;
            $display("FAIL idle_grant: gnt=%b sel=%0d expected gnt=1000 sel=15", GNT, MUX_SELECT);
        end
        REQ = '0;
        step();
        old = regs[15];
        total++;
        if (GNT !== '0 || RVALID !== 4'b1000 || RDATA !== old) begin
            bad++;
            $display("FAIL idle_capture: gnt=%b rvalid=%b rdata=%h expected 0000 1000 %h",
                     GNT, RVALID, RDATA, old);
        end
        regs[15] = 32'h5A5A_1234;
        step();
        total++;
        if (GNT !== '0 || RVALID !== '0 || MUX_SELECT !== 4'd15 || RDATA !== old || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: gnt=%b rvalid=%b sel=%0d rdata=%h busy=%b expected 0000 0000 15 %h 0",
                     GNT, RVALID, MUX_SELECT, RDATA, BUSY, old);
        end
        regs[15] = old;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i * 32'h111);
        regs[9] = 32'hDEADBEEF;
        test_reset();
        test_rotation();
        test_single_read();
        test_held_req();
        test_idle();
        step();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d reads outstanding, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
